// File: rtl/mmio_controller.sv
// MMIO controller: decodes processor loads/stores into RAM, button-flag and
// VGA-mailbox classes, with a uniform one-cycle read latency on q_dmem.
module mmio_controller #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OUT_ADDR  = 2000,
  parameter int unsigned STAT_ADDR = 2001,
  parameter int unsigned BTNL_ADDR = 3000,
  parameter int unsigned BTNR_ADDR = 4000,
  parameter int unsigned BTNU_ADDR = 5000,
  parameter int unsigned BTND_ADDR = 6000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_dmem,
  input  logic [31:0] ram_dout,
  output logic        ram_wen,
  input  logic [3:0]  btn_in,
  output logic [31:0] vga_data,
  output logic        vga_valid,
  input  logic        vga_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    CLS_RAM, CLS_OUT, CLS_STAT, CLS_BTNL, CLS_BTNR, CLS_BTNU, CLS_BTND
  } cls_e;

  cls_e          cls_c, cls_q;
  logic [31:0]   rd_d, rd_q;
  logic [3:0]    flag_d, flag_q, btn_prev_q, btn_clr_c;
  logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic          ovf_d, ovf_q;
  logic [31:0]   mem_q [DEPTH];
  logic          load_c, push_c, pop_c, full_c, push_ok_c;

  // Full 32-bit address decode; anything unmatched belongs to RAM.
  always_comb begin
    cls_c = CLS_RAM;
    if (address_dmem == 32'(OUT_ADDR))       cls_c = CLS_OUT;
    else if (address_dmem == 32'(STAT_ADDR)) cls_c = CLS_STAT;
    else if (address_dmem == 32'(BTNL_ADDR)) cls_c = CLS_BTNL;
    else if (address_dmem == 32'(BTNR_ADDR)) cls_c = CLS_BTNR;
    else if (address_dmem == 32'(BTNU_ADDR)) cls_c = CLS_BTNU;
    else if (address_dmem == 32'(BTND_ADDR)) cls_c = CLS_BTND;
  end

  assign ram_wen   = wren & (cls_c == CLS_RAM);
  assign vga_valid = (count_q != '0);
  assign vga_data  = mem_q[rd_ptr_q];
  assign q_dmem    = (cls_q == CLS_RAM) ? ram_dout : rd_q;

  always_comb begin
    load_c    = ~wren;
    push_c    = wren & (cls_c == CLS_OUT);
    pop_c     = vga_valid & vga_ready;
    full_c    = (count_q == FULL_CNT);
    push_ok_c = push_c & (~full_c | pop_c);

    btn_clr_c = '0;
    if (load_c) begin
      case (cls_c)
        CLS_BTNL: btn_clr_c[0] = 1'b1;
        CLS_BTNR: btn_clr_c[1] = 1'b1;
        CLS_BTNU: btn_clr_c[2] = 1'b1;
        CLS_BTND: btn_clr_c[3] = 1'b1;
        default:  btn_clr_c    = '0;
      endcase
    end
    // A rising edge in the same cycle as a clearing load keeps the flag set.
    flag_d = (flag_q & ~btn_clr_c) | (btn_in & ~btn_prev_q);

    ovf_d = ovf_q;
    if (load_c && (cls_c == CLS_STAT)) ovf_d = 1'b0;
    if (push_c && full_c && !pop_c)    ovf_d = 1'b1;

    wr_ptr_d = wr_ptr_q + PW'(push_ok_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    count_d  = count_q + CW'(push_ok_c) - CW'(pop_c);

    // Read words reflect state before the edge that captures them.
    rd_d = '0;
    case (cls_c)
      CLS_BTNL: rd_d = {31'b0, flag_q[0]};
      CLS_BTNR: rd_d = {31'b0, flag_q[1]};
      CLS_BTNU: rd_d = {31'b0, flag_q[2]};
      CLS_BTND: rd_d = {31'b0, flag_q[3]};
      CLS_STAT: rd_d = {22'b0, ovf_q, full_c, 8'(count_q)};
      default:  rd_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cls_q      <= CLS_RAM;
      rd_q       <= '0;
      flag_q     <= '0;
      btn_prev_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cls_q      <= cls_c;
      rd_q       <= rd_d;
      flag_q     <= flag_d;
      btn_prev_q <= btn_in;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Mailbox storage needs no reset; count gates its visibility.
  always_ff @(posedge clock) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= data;
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Scoreboard bench for mmio_controller: queue-based reference model, directed
// scenarios followed by randomized loads/stores, buttons and VGA back-pressure.
module tb_mmio_controller;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] A_OUT  = 32'd2000;
  localparam logic [31:0] A_STAT = 32'd2001;
  localparam logic [31:0] A_BTNL = 32'd3000;
  localparam logic [31:0] A_BTNR = 32'd4000;
  localparam logic [31:0] A_BTNU = 32'd5000;
  localparam logic [31:0] A_BTND = 32'd6000;

  logic        clock, reset, wren, ram_wen, vga_valid, vga_ready;
  logic [31:0] address_dmem, data, q_dmem, ram_dout, vga_data;
  logic [3:0]  btn_in;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_controller #(
    .DEPTH(DEPTH), .OUT_ADDR(2000), .STAT_ADDR(2001), .BTNL_ADDR(3000),
    .BTNR_ADDR(4000), .BTNU_ADDR(5000), .BTND_ADDR(6000)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
    .data(data), .q_dmem(q_dmem), .ram_dout(ram_dout), .ram_wen(ram_wen),
    .btn_in(btn_in), .vga_data(vga_data), .vga_valid(vga_valid),
    .vga_ready(vga_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment RAM: synchronous, read-before-write, driven only by ram_wen.
  logic [31:0] ram_mem [256];
  initial for (int i = 0; i < 256; i++) ram_mem[i] = '0;
  always @(posedge clock) begin
    ram_dout <= ram_mem[address_dmem[7:0]];
    if (ram_wen) ram_mem[address_dmem[7:0]] <= data;
  end

  function automatic bit is_mmio(input logic [31:0] a);
    return (a == A_OUT) || (a == A_STAT) || (a == A_BTNL) || (a == A_BTNR) ||
           (a == A_BTNU) || (a == A_BTND);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [256];
  logic [3:0]  m_flag = '0;
  logic [3:0]  m_prev = '0;
  bit          m_ovf  = 1'b0;
  int          m_count = 0;
  logic [31:0] exp_vga [$];
  logic [31:0] ld_exp  [$];
  initial for (int i = 0; i < 256; i++) m_mem[i] = '0;

  always @(posedge clock or negedge reset) begin
    logic [31:0] e;
    logic [3:0]  clr;
    bit          pop;
    if (!reset) begin
      m_flag = '0; m_prev = '0; m_ovf = 1'b0; m_count = 0;
      exp_vga.delete(); ld_exp.delete();
    end else begin
      pop = (m_count != 0) && vga_ready;
      clr = '0;
      if (!wren) begin
        if (!is_mmio(address_dmem)) e = m_mem[address_dmem[7:0]];
        else if (address_dmem == A_STAT)
          e = {22'b0, m_ovf, (m_count == int'(DEPTH)), 8'(m_count)};
        else if (address_dmem == A_BTNL) begin e = {31'b0, m_flag[0]}; clr[0] = 1'b1; end
        else if (address_dmem == A_BTNR) begin e = {31'b0, m_flag[1]}; clr[1] = 1'b1; end
        else if (address_dmem == A_BTNU) begin e = {31'b0, m_flag[2]}; clr[2] = 1'b1; end
        else if (address_dmem == A_BTND) begin e = {31'b0, m_flag[3]}; clr[3] = 1'b1; end
        else e = '0;
        ld_exp.push_back(e);
        if (address_dmem == A_STAT) m_ovf = 1'b0;
      end
      m_flag = (m_flag & ~clr) | (btn_in & ~m_prev);
      m_prev = btn_in;
      if (wren && address_dmem == A_OUT) begin
        if (m_count < int'(DEPTH) || pop) begin
          exp_vga.push_back(data);
          m_count++;
        end else m_ovf = 1'b1;
      end
      if (pop) m_count--;
      if (wren && !is_mmio(address_dmem)) m_mem[address_dmem[7:0]] = data;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  always @(negedge clock) begin
    logic [31:0] e;
    chk("ram_wen", 32'(ram_wen), 32'(wren && !is_mmio(address_dmem)));
    chk("vga_valid", 32'(vga_valid), 32'(m_count != 0));
    if (vga_valid && vga_ready) begin
      if (exp_vga.size() > 0) begin
        e = exp_vga.pop_front();
        chk("vga_data", vga_data, e);
      end else begin
        n_cmp++; n_bad++;
        $display("FAIL vga_extra: got word %h with nothing expected at %0t", vga_data, $time);
      end
    end
    if (ld_exp.size() > 0) begin
      e = ld_exp.pop_front();
      chk("q_dmem", q_dmem, e);
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    wren = w; address_dmem = a; data = d;
    @(posedge clock); #1;
  endtask

  logic [31:0] addr_tbl [10] = '{32'd0, 32'd1, 32'd5, 32'd100, 32'd2000,
                                 32'd2001, 32'd3000, 32'd4000, 32'd5000, 32'd6000};

  initial begin
    reset = 1'b0; wren = 1'b0; address_dmem = '0; data = '0;
    vga_ready = 1'b0; btn_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset then idle
    chk("rst_valid", 32'(vga_valid), 32'd0);
    drive(1'b0, A_STAT, '0); chk("rst_stat", q_dmem, 32'h0);
    drive(1'b0, A_BTNL, '0); chk("rst_btnl", q_dmem, 32'h0);

    // Held button sets the flag once; load clears it
    btn_in = 4'b0001;
    repeat (10) drive(1'b0, 32'd0, '0);
    drive(1'b0, A_BTNL, '0); chk("btnl_first", q_dmem, 32'h1);
    drive(1'b0, A_BTNL, '0); chk("btnl_second", q_dmem, 32'h0);
    drive(1'b0, A_BTNR, '0); chk("btnr", q_dmem, 32'h0);
    btn_in = 4'b0000;

    // Three words, then drain
    drive(1'b1, A_OUT, 32'hA); drive(1'b1, A_OUT, 32'hB); drive(1'b1, A_OUT, 32'hC);
    drive(1'b0, A_STAT, '0); chk("stat_three", q_dmem, 32'h003);
    vga_ready = 1'b1;
    repeat (3) drive(1'b0, 32'd0, '0);
    chk("drain_valid", 32'(vga_valid), 32'd0);
    vga_ready = 1'b0;

    // Overflow: fifth word is dropped
    for (int i = 1; i <= 5; i++) drive(1'b1, A_OUT, 32'h10 + 32'(i));
    drive(1'b0, A_STAT, '0); chk("stat_ovf", q_dmem, 32'h304);
    drive(1'b0, A_STAT, '0); chk("stat_ovf_clr", q_dmem, 32'h104);
    vga_ready = 1'b1;
    repeat (5) drive(1'b0, 32'd0, '0);
    chk("ovf_drain_valid", 32'(vga_valid), 32'd0);
    vga_ready = 1'b0;

    // RAM store/load and MMIO store isolation
    wren = 1'b1; address_dmem = 32'd100; data = 32'h55;
    #2 chk("ram_wen_store", 32'(ram_wen), 32'd1);
    @(posedge clock); #1;
    drive(1'b0, 32'd100, '0); chk("ram_load", q_dmem, 32'h55);
    wren = 1'b1; address_dmem = A_BTNL; data = 32'hFFFF;
    #2 chk("ram_wen_btn", 32'(ram_wen), 32'd0);
    @(posedge clock); #1;

    // Full FIFO with simultaneous push and pop, then mid-stream reset
    for (int i = 1; i <= 4; i++) drive(1'b1, A_OUT, 32'h20 + 32'(i));
    vga_ready = 1'b1;
    drive(1'b1, A_OUT, 32'h25);
    vga_ready = 1'b0;
    drive(1'b0, A_STAT, '0); chk("stat_full_pp", q_dmem, 32'h104);
    vga_ready = 1'b1;
    repeat (2) drive(1'b0, 32'd0, '0);
    reset = 1'b0;
    #1 chk("reset_valid", 32'(vga_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      vga_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) btn_in = 4'($urandom);
      drive(1'($urandom_range(0, 2) == 0), addr_tbl[$urandom_range(0, 9)], $urandom);
    end
    vga_ready = 1'b1;
    repeat (8) drive(1'b0, 32'd0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
